// File: rtl/color_classifier.sv
// Color classifier: averages 2^AVG_LOG2 normalized RGB/clear samples per window,
// then reports the strictly dominant channel (or NONE when dark or tied).
// Optional feature macro: CLASSIFY_DEBOUNCE_EN. When it is defined, the reported
// color only changes after STABLE_COUNT identical consecutive decisions.
module color_classifier #(
   parameter int WIDTH        = 16,
   parameter int AVG_LOG2     = 2,
   parameter int DARK_THRESH  = 1000,
   parameter int STABLE_COUNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] red,
   input  logic [WIDTH-1:0] green,
   input  logic [WIDTH-1:0] blue,
   input  logic [WIDTH-1:0] clear,
   output logic [1:0]       color,
   output logic             color_valid,
   output logic             overrun
);

   localparam int AW = WIDTH + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam logic [CW-1:0]    LAST_CNT = CW'((1 << AVG_LOG2) - 1);
   localparam logic [WIDTH-1:0] DARK_W   = WIDTH'(DARK_THRESH);

   localparam logic [1:0] C_NONE  = 2'd0;
   localparam logic [1:0] C_RED   = 2'd1;
   localparam logic [1:0] C_GREEN = 2'd2;
   localparam logic [1:0] C_BLUE  = 2'd3;

   typedef enum logic [1:0] {ACCUM, COMPARE, DECIDE} state_t;

   state_t           state_q;
   logic [AW-1:0]    acc_r_q, acc_g_q, acc_b_q, acc_c_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] avg_r_q, avg_g_q, avg_b_q, avg_c_q;
   logic [1:0]       color_q;
   logic             valid_q;
   logic             overrun_q;
   logic [1:0]       dec_d;
   logic [1:0]       color_d;

   // Raw decision from the registered averages: dark or any tie for the max gives NONE.
   always_comb begin
      dec_d = C_NONE;
      if (avg_c_q >= DARK_W) begin
         if (avg_r_q > avg_g_q && avg_r_q > avg_b_q)
            dec_d = C_RED;
         else if (avg_g_q > avg_r_q && avg_g_q > avg_b_q)
            dec_d = C_GREEN;
         else if (avg_b_q > avg_r_q && avg_b_q > avg_g_q)
            dec_d = C_BLUE;
      end
   end

`ifdef CLASSIFY_DEBOUNCE_EN
   localparam int RW = $clog2(STABLE_COUNT + 1);
   localparam logic [RW-1:0] STABLE_W = RW'(STABLE_COUNT);

   logic [1:0]    cand_q;
   logic [RW-1:0] run_q;
   logic [RW-1:0] run_d;

   // Run length of the current candidate (saturating) and the debounced color it implies.
   always_comb begin
      run_d = RW'(1);
      if (dec_d == cand_q)
         run_d = (run_q >= STABLE_W) ? run_q : run_q + RW'(1);
      color_d = (run_d >= STABLE_W) ? dec_d : color_q;
   end

   // Candidate/run registers advance once per window, in the DECIDE step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_q <= C_NONE;
         run_q  <= '0;
      end else if (state_q == DECIDE) begin
         cand_q <= dec_d;
         run_q  <= run_d;
      end
   end
`else
   // Without debounce every window's raw decision is reported directly.
   always_comb begin
      color_d = dec_d;
   end
`endif

   // Window FSM: accumulate N samples, latch averages, then publish the decision.
   // The averages take the top WIDTH bits of each accumulator, i.e. acc >> AVG_LOG2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ACCUM;
         acc_r_q   <= '0;
         acc_g_q   <= '0;
         acc_b_q   <= '0;
         acc_c_q   <= '0;
         cnt_q     <= '0;
         avg_r_q   <= '0;
         avg_g_q   <= '0;
         avg_b_q   <= '0;
         avg_c_q   <= '0;
         color_q   <= C_NONE;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         case (state_q)
            ACCUM: begin
               if (sample_valid) begin
                  acc_r_q <= acc_r_q + AW'(red);
                  acc_g_q <= acc_g_q + AW'(green);
                  acc_b_q <= acc_b_q + AW'(blue);
                  acc_c_q <= acc_c_q + AW'(clear);
                  if (cnt_q == LAST_CNT) begin
                     cnt_q   <= '0;
                     state_q <= COMPARE;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            COMPARE: begin
               avg_r_q   <= acc_r_q[AW-1:AVG_LOG2];
               avg_g_q   <= acc_g_q[AW-1:AVG_LOG2];
               avg_b_q   <= acc_b_q[AW-1:AVG_LOG2];
               avg_c_q   <= acc_c_q[AW-1:AVG_LOG2];
               overrun_q <= sample_valid;
               state_q   <= DECIDE;
            end
            DECIDE: begin
               color_q   <= color_d;
               valid_q   <= 1'b1;
               acc_r_q   <= '0;
               acc_g_q   <= '0;
               acc_b_q   <= '0;
               acc_c_q   <= '0;
               overrun_q <= sample_valid;
               state_q   <= ACCUM;
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign color       = color_q;
   assign color_valid = valid_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_color_classifier.sv
// Self-checking bench for color_classifier with a window-level reference model.
module tb_color_classifier;
   localparam int N      = 4;
   localparam int DARK   = 1000;
   localparam int STABLE = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_valid;
   logic [15:0] red, green, blue, clear;
   logic [1:0]  color;
   logic        color_valid;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   longint sum_r, sum_g, sum_b, sum_c;
   int     hist[$];
   int     m_color;

   color_classifier dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid),
      .red(red), .green(green), .blue(blue), .clear(clear),
      .color(color), .color_valid(color_valid), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "timeout");
   end

   // Reference: integer-divided window means, dark test, strict maximum.
   function automatic int raw_decision(longint sr, longint sg, longint sb, longint sc);
      longint ar, ag, ab, ac;
      ar = sr / N; ag = sg / N; ab = sb / N; ac = sc / N;
      if (ac < DARK) return 0;
      if (ar > ag && ar > ab) return 1;
      if (ag > ar && ag > ab) return 2;
      if (ab > ar && ab > ag) return 3;
      return 0;
   endfunction

   task automatic model_reset();
      sum_r = 0; sum_g = 0; sum_b = 0; sum_c = 0;
      hist.delete();
      m_color = 0;
   endtask

   task automatic model_window_done();
      int raw;
      bit same;
      raw = raw_decision(sum_r, sum_g, sum_b, sum_c);
      sum_r = 0; sum_g = 0; sum_b = 0; sum_c = 0;
      hist.push_back(raw);
`ifdef CLASSIFY_DEBOUNCE_EN
      if (hist.size() >= STABLE) begin
         same = 1'b1;
         for (int i = hist.size() - STABLE; i < hist.size(); i++)
            if (hist[i] != raw) same = 1'b0;
         if (same) m_color = raw;
      end
`else
      same = 1'b1;
      if (same) m_color = raw;
`endif
   endtask

   // Entered and left at a falling edge; exactly one rising edge accepts the sample.
   task automatic send(input int r, input int g, input int b, input int c);
      red = 16'(r); green = 16'(g); blue = 16'(b); clear = 16'(c);
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      sum_r += r; sum_g += g; sum_b += b; sum_c += c;
   endtask

   task automatic send4(input int r, input int g, input int b, input int c);
      for (int i = 0; i < N; i++) send(r, g, b, c);
   endtask

   // Counts falling edges until color_valid (bounded); lat = -1 if it never came.
   task automatic wait_valid(output int lat, output logic [1:0] got);
      lat = -1; got = 2'd0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (color_valid === 1'b1) begin
            lat = k; got = color;
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; sample_valid = 1'b0;
      red = '0; green = '0; blue = '0; clear = '0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++; if (color !== 2'd0) begin errors++; $display("FAIL reset_color got %0d want 0", color); end
      checks++; if (color_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", color_valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_red();
      int lat; logic [1:0] got;
      send4(5000, 2000, 1000, 40000);
      checks++; if (color_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b want 0", color_valid); end
      model_window_done();
      wait_valid(lat, got);
      checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", lat); end
      checks++; if (got !== 2'(m_color)) begin errors++; $display("FAIL basic_color got %0d want %0d", got, m_color); end
      @(negedge clk);
      checks++; if (color_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %0b want 0", color_valid); end
   endtask

   task automatic test_width();
      int lat; logic [1:0] got;
      send4(65535, 100, 100, 40000);
      model_window_done();
      wait_valid(lat, got);
      checks++; if (lat !== 2) begin errors++; $display("FAIL width_latency got %0d want 2", lat); end
      checks++; if (got !== 2'(m_color)) begin errors++; $display("FAIL width_color got %0d want %0d", got, m_color); end
   endtask

   task automatic test_dark_tie();
      int lat; logic [1:0] got;
      send4(9000, 100, 100, 500);
      model_window_done();
      wait_valid(lat, got);
      checks++; if (lat !== 2) begin errors++; $display("FAIL dark_latency got %0d want 2", lat); end
      checks++; if (got !== 2'(m_color)) begin errors++; $display("FAIL dark_color got %0d want %0d", got, m_color); end
      send4(3000, 3000, 1000, 40000);
      model_window_done();
      wait_valid(lat, got);
      checks++; if (lat !== 2) begin errors++; $display("FAIL tie_latency got %0d want 2", lat); end
      checks++; if (got !== 2'(m_color)) begin errors++; $display("FAIL tie_color got %0d want %0d", got, m_color); end
   endtask

   task automatic test_overrun();
      int lat; logic [1:0] got; bit early;
      send4(5000, 2000, 1000, 40000);
      model_window_done();
      // Now in the COMPARE cycle: this sample must be dropped.
      red = 16'd100; green = 16'd100; blue = 16'd60000; clear = 16'd60000;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse got %0b want 1", overrun); end
      @(negedge clk);
      checks++; if (color_valid !== 1'b1) begin errors++; $display("FAIL overrun_window_valid got %0b want 1", color_valid); end
      checks++; if (color !== 2'(m_color)) begin errors++; $display("FAIL overrun_window_color got %0d want %0d", color, m_color); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_single got %0b want 0", overrun); end
      for (int i = 0; i < 3; i++) send(1000, 7000, 2000, 30000);
      early = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (color_valid === 1'b1) early = 1'b1;
      end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL overrun_counted got %0b want 0", early); end
      send(1000, 7000, 2000, 30000);
      model_window_done();
      wait_valid(lat, got);
      checks++; if (lat !== 2) begin errors++; $display("FAIL overrun_next_latency got %0d want 2", lat); end
      checks++; if (got !== 2'(m_color)) begin errors++; $display("FAIL overrun_next_color got %0d want %0d", got, m_color); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [1:0] got; bit early;
      send4(5000, 2000, 1000, 40000);
      model_window_done();
      wait_valid(lat, got);
      send(100, 100, 65535, 65535);
      send(100, 100, 65535, 65535);
      rst = 1'b1;
      #1;
      checks++; if (color !== 2'd0) begin errors++; $display("FAIL rstmid_color got %0d want 0", color); end
      checks++; if (color_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", color_valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got %0b want 0", overrun); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) send(3000, 2000, 2500, 5000);
      early = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (color_valid === 1'b1) early = 1'b1;
      end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL rstmid_early_valid got %0b want 0", early); end
      send(3000, 2000, 2500, 5000);
      model_window_done();
      wait_valid(lat, got);
      checks++; if (lat !== 2) begin errors++; $display("FAIL rstmid_latency got %0d want 2", lat); end
      checks++; if (got !== 2'(m_color)) begin errors++; $display("FAIL rstmid_color_after got %0d want %0d", got, m_color); end
   endtask

   task automatic test_random();
      int lat; logic [1:0] got; int r, g, b, c; bit tie, dim;
      for (int w = 0; w < 16; w++) begin
         tie = ($urandom_range(0, 3) == 0);
         dim = ($urandom_range(0, 3) == 0);
         for (int s = 0; s < N; s++) begin
            r = int'($urandom_range(0, 65535));
            g = tie ? r : int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 65535));
            c = dim ? int'($urandom_range(0, 1500)) : int'($urandom_range(0, 65535));
            send(r, g, b, c);
         end
         model_window_done();
         wait_valid(lat, got);
         checks++; if (lat !== 2) begin errors++; $display("FAIL rand_latency w%0d got %0d want 2", w, lat); end
         checks++; if (got !== 2'(m_color)) begin errors++; $display("FAIL rand_color w%0d got %0d want %0d", w, got, m_color); end
         repeat (1 + $urandom_range(0, 2)) @(negedge clk);
         checks++; if (color !== 2'(m_color)) begin errors++; $display("FAIL rand_hold w%0d got %0d want %0d", w, color, m_color); end
      end
   endtask

   task automatic test_debounce();
      int lat; logic [1:0] got;
      int seq [6] = '{1, 1, 3, 1, 1, 1};
`ifdef CLASSIFY_DEBOUNCE_EN
      int want [6] = '{0, 0, 0, 0, 0, 1};
`else
      int want [6] = '{1, 1, 3, 1, 1, 1};
`endif
      pulse_reset();
      for (int w = 0; w < 6; w++) begin
         if (seq[w] == 1) send4(5000, 2000, 1000, 40000);
         else             send4(1000, 2000, 5000, 40000);
         model_window_done();
         wait_valid(lat, got);
         checks++; if (lat !== 2) begin errors++; $display("FAIL deb_latency w%0d got %0d want 2", w, lat); end
         checks++; if (got !== 2'(want[w])) begin errors++; $display("FAIL deb_color w%0d got %0d want %0d", w, got, want[w]); end
         checks++; if (got !== 2'(m_color)) begin errors++; $display("FAIL deb_model w%0d got %0d want %0d", w, got, m_color); end
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [1:0] got;
      // Valid held high across the window boundary: the 5th strobe lands in COMPARE.
      for (int i = 0; i < N; i++) send(1000, 9000, 2000, 20000);
      model_window_done();
      red = 16'd1000; green = 16'd9000; blue = 16'd2000; clear = 16'd20000;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %0b want 1", overrun); end
      wait_valid(lat, got);
      checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_latency got %0d want 1", lat); end
      checks++; if (got !== 2'(m_color)) begin errors++; $display("FAIL b2b_color got %0d want %0d", got, m_color); end
   endtask

   initial begin
      test_reset();
      test_basic_red();
      test_width();
      test_dark_tie();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_debounce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/color_classifier.md
COLOR_CLASSIFIER -- requirements
Module: color_classifier

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16: width of the normalized color quotients and of clear.
REQ-002 The block SHALL take parameter AVG_LOG2, default 2: log2 of the number of samples averaged per decision window (N = 2^AVG_LOG2).
REQ-003 The block SHALL take parameter DARK_THRESH, default 1000: an averaged clear below this value means no object present.
REQ-004 The block SHALL take parameter STABLE_COUNT, default 3: consecutive identical decisions required by the debounce.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port sample_valid, input, 1 bit: single-cycle strobe marking red, green, blue and clear as valid.
REQ-008 The block SHALL have ports red, green and blue, inputs, WIDTH bits each: normalized quotients from the dividers; a larger value means a stronger component.
REQ-009 The block SHALL have port clear, input, WIDTH bits: raw clear-channel frequency count.
REQ-010 The block SHALL have port color, output, 2 bits: 0 NONE, 1 RED, 2 GREEN, 3 BLUE.
REQ-011 The block SHALL have port color_valid, output, 1 bit: one-cycle pulse at the end of each decision window.
REQ-012 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a sample_valid is dropped.

Function
REQ-013 The state machine SHALL have states ACCUM, COMPARE and DECIDE; it leaves reset in ACCUM.
REQ-014 In ACCUM, each sample_valid SHALL add red, green, blue and clear into four accumulators of WIDTH+AVG_LOG2 bits and increment a sample counter; accumulators never overflow.
REQ-015 On the clock edge that accepts sample N, the FSM SHALL go to COMPARE and clear the sample counter.
REQ-016 In COMPARE, the averages SHALL be registered as accumulator >> AVG_LOG2, truncated to WIDTH bits with no rounding; the FSM then goes to DECIDE.
REQ-017 If the averaged clear is below DARK_THRESH, the DECIDE step SHALL produce NONE.
REQ-018 Otherwise, DECIDE SHALL produce the channel whose average is strictly greatest; any tie for the maximum produces NONE.
REQ-019 In DECIDE, the block SHALL update color, pulse color_valid for exactly one cycle, clear all accumulators and return to ACCUM.
REQ-020 Latency SHALL be fixed: color_valid is high in the second cycle after the edge that accepts sample N, and color is updated in that same cycle.
REQ-021 A sample_valid arriving in COMPARE or DECIDE SHALL be discarded, not accumulated, and SHALL pulse overrun in the following cycle.
REQ-022 color SHALL hold its value between decisions.
REQ-023 sample_valid held high for multiple cycles in ACCUM SHALL be accepted once per cycle.

Reset
REQ-024 Asserting rst SHALL immediately force the state to ACCUM and clear the accumulators, sample counter, averages and debounce registers.
REQ-025 Asserting rst SHALL immediately force color=0, color_valid=0 and overrun=0.
REQ-026 rst asserted mid-window SHALL discard the partial window; the next decision requires N fresh samples after rst deasserts.

Configuration
REQ-027 When CLASSIFY_DEBOUNCE_EN is defined, each raw decision SHALL update a candidate and a run counter.
REQ-028 With CLASSIFY_DEBOUNCE_EN defined, color SHALL change only when the candidate has been identical for STABLE_COUNT consecutive decisions; color_valid still pulses every window.
REQ-029 When CLASSIFY_DEBOUNCE_EN is not defined, color SHALL take the raw decision of every window, and no candidate or run-counter logic is synthesized.

Verification
REQ-030 The bench SHALL cover a basic RED decision: 4 samples of red=5000, green=2000, blue=1000, clear=40000 -> color=1 and one color_valid pulse exactly 2 cycles after the 4th sample edge.
REQ-031 The bench SHALL cover averaging and width: red=65535 ×4 with green=blue=100 and clear=40000 -> red average 65535 with no overflow, color=1.
REQ-032 The bench SHALL cover dark and tie cases: (a) clear=500 ×4 with red=9000 -> color=0; (b) red=green=3000, blue=1000, clear=40000 -> color=0.
REQ-033 The bench SHALL cover overrun: sample_valid pulsed in the COMPARE cycle -> overrun pulse, sample not counted, and the next window still needs 4 samples.
REQ-034 The bench SHALL cover reset mid-window: rst asserted after 2 samples -> all outputs 0 at once, and no color_valid until 4 samples after release.
REQ-035 The bench SHALL cover debounce: windows RED, RED, BLUE, RED, RED, RED -> with CLASSIFY_DEBOUNCE_EN, color=0 until the 6th window, then 1; without it, color follows 1,1,3,1,1,1.
